// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRIVE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_deser.sv
// LSB-first shift-in register: each enabled edge pushes bit_i in at the top,
// so after WIDTH loads the first bit received sits in data_o[0].
module serial_adder_deser #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] shifted;

    generate
        if (WIDTH == 1) begin : g_single
            assign shifted = bit_i;
        end else begin : g_multi
            assign shifted = {bit_i, data_q[WIDTH-1:1]};
        end
    endgenerate

    // Next value: shift only when loading.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = shifted;
        end
    end

    // Shift register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/serial_adder_n.sv
// Bit-serial WIDTH-bit add/subtract unit. Operands arrive LSB first starting
// on en_i; the WIDTH+1-bit result leaves LSB first with en_o on bit 0.
// Optional macro SERIAL_ADDER_N_ERR_EN adds err_o, a one-cycle pulse for
// every en_i seen while a transaction is in progress.
module serial_adder_n
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in1,
    input  logic in2,
    input  logic en_i,
    input  logic sub_i,
`ifdef SERIAL_ADDER_N_ERR_EN
    output logic err_o,
`endif
    output logic out,
    output logic en_o,
    output logic busy
);

    // Counter spans 0..WIDTH (LOAD bit index, then DRIVE result index).
    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sub_q, sub_d;
    logic             out_q, out_d;
    logic             en_o_q, en_o_d;
    logic             shift_en;
    logic [WIDTH-1:0] a_val, b_val;
    logic [WIDTH:0]   sum_add, sum_sub, result;

    serial_adder_deser #(.WIDTH(WIDTH)) u_deser_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (shift_en),
        .bit_i  (in1),
        .data_o (a_val)
    );

    serial_adder_deser #(.WIDTH(WIDTH)) u_deser_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (shift_en),
        .bit_i  (in2),
        .data_o (b_val)
    );

    assign sum_add = {1'b0, a_val} + {1'b0, b_val};
    assign sum_sub = {1'b0, a_val} + {1'b0, ~b_val} + (WIDTH + 1)'(1);
    assign result  = (sub_q == MODE_ADD) ? sum_add : sum_sub;

    // Next-state, counter and output-bit selection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sub_d    = sub_q;
        shift_en = 1'b0;
        out_d    = 1'b0;
        en_o_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i) begin
                    shift_en = 1'b1;
                    sub_d    = sub_i;
                    if (WIDTH > 1) begin
                        state_d = LOAD;
                        cnt_d   = CW'(1);
                    end else begin
                        state_d = DRIVE;
                        cnt_d   = CW'(0);
                    end
                end
            end
            LOAD: begin
                shift_en = 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DRIVE;
                    cnt_d   = CW'(0);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRIVE: begin
                out_d  = result[cnt_q];
                en_o_d = (cnt_q == CW'(0));
                if (cnt_q == CW'(WIDTH)) begin
                    state_d = IDLE;
                    cnt_d   = CW'(0);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CW'(0);
            end
        endcase
    end

    // State, counter, mode and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sub_q   <= MODE_ADD;
            out_q   <= 1'b0;
            en_o_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            out_q   <= out_d;
            en_o_q  <= en_o_d;
        end
    end

`ifdef SERIAL_ADDER_N_ERR_EN
    logic err_q;

    // Flag a start strobe that arrives while a transaction is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= en_i && (state_q != IDLE);
        end
    end

    assign err_o = err_q;
`endif

    assign out  = out_q;
    assign en_o = en_o_q;
    assign busy = (state_q != IDLE);

endmodule
